// File: rtl/seg_scan_if.sv
// seg_scan_if: handshake and display bus between requester, scan controller and seg7 decoder
//   en, load            scan enable and capture request (requester -> controller)
//   digits_in, dp_in    nibble i / dp bit i belong to digit i (requester -> controller)
//   dec_digit, dec_dp   nibble and decimal point for the shared decoder (controller -> display)
//   dig_en              one-hot digit enable, all-zero while blanked (controller -> display)
//   frame_start         1-cycle pulse on entry to the digit-0 slot
//   load_ack            1-cycle pulse when the shadow registers capture
interface seg_scan_if #(parameter int NUM_DIGITS = 4);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              dec_digit;
  logic                    dec_dp;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_start;
  logic                    load_ack;
  modport master (
    output en, load, digits_in, dp_in,
    input  dec_digit, dec_dp, dig_en, frame_start, load_ack
  );
  modport slave (
    input  en, load, digits_in, dp_in,
    output dec_digit, dec_dp, dig_en, frame_start, load_ack
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scan controller with dead-time and frame-boundary load
//   clk, rst  clock and asynchronous active-high reset
//   bus       seg_scan_if.slave: en/load/digits_in/dp_in in; dec_digit/dec_dp/dig_en/frame_start/load_ack out
//   Optional: define SEG_SCAN_LZB_EN for leading-zero blanking (digit 0 is never blanked).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_END   = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_digits, w_digits_nxt;
  logic [NUM_DIGITS-1:0]   r_dp, w_dp_nxt;
  logic [NUM_DIGITS-1:0]   r_dig_en, w_dig_en_nxt;
  logic [3:0]              r_dec_digit, w_dec_digit_nxt;
  logic                    r_dec_dp, w_dec_dp_nxt;
  logic                    r_frame, r_ack;
  logic                    w_frame, w_ack;
  logic [NUM_DIGITS-1:0]   w_lz;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_frame     = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_frame     = 1'b1;
      end
      BLANK: w_state_nxt = (r_cnt == BLANK_END) ? SHOW : BLANK;
      SHOW: if (r_cnt == SLOT_END) begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = (r_idx == IDX_END) ? '0 : r_idx + 1'b1;
        w_frame     = (r_idx == IDX_END);
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_frame     = 1'b0;
    end
    w_ack           = w_frame & bus.load;
    w_digits_nxt    = w_ack ? bus.digits_in : r_digits;
    w_dp_nxt        = w_ack ? bus.dp_in : r_dp;
    // outputs are registered, so they are derived from the next state and next shadow;
    // that way a capture at a frame boundary is visible from the first BLANK cycle of digit 0
    w_dig_en_nxt    = (w_state_nxt == SHOW && !w_lz[w_idx_nxt]) ? NUM_DIGITS'(1) << w_idx_nxt : '0;
    w_dec_digit_nxt = (w_state_nxt == IDLE) ? 4'h0 : w_digits_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_dec_dp_nxt    = (w_state_nxt == IDLE) ? 1'b0 : w_dp_nxt[w_idx_nxt];
  end
`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] w_zero;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign w_zero[i] = (w_digits_nxt[4*i +: 4] == 4'h0);
    if (i == 0) begin : g_lo
      assign w_lz[i] = 1'b0;
    end else begin : g_hi
      assign w_lz[i] = &w_zero[NUM_DIGITS-1:i];
    end
  end
`else
  assign w_lz = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_digits    <= '0;
      r_dp        <= '0;
      r_dig_en    <= '0;
      r_dec_digit <= '0;
      r_dec_dp    <= 1'b0;
      r_frame     <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_digits    <= w_digits_nxt;
      r_dp        <= w_dp_nxt;
      r_dig_en    <= w_dig_en_nxt;
      r_dec_digit <= w_dec_digit_nxt;
      r_dec_dp    <= w_dec_dp_nxt;
      r_frame     <= w_frame;
      r_ack       <= w_ack;
    end
  end
  assign bus.dig_en      = r_dig_en;
  assign bus.dec_digit   = r_dec_digit;
  assign bus.dec_dp      = r_dec_dp;
  assign bus.frame_start = r_frame;
  assign bus.load_ack    = r_ack;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, frame-boundary load, en/rst behaviour and leading-zero blanking
module tb_seg_scan_ctrl;
  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRM = N * DIV;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  seg_scan_if #(.NUM_DIGITS(N)) bus ();
  seg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // p = cycle within the frame, shown = shadow value on display, lit = digits not blanked
  task automatic chk_scan(input int p, input logic [15:0] shown, input logic [3:0] dp,
                          input logic ack, input logic [3:0] lit);
    int s = p / DIV;
    chk($sformatf("dig_en@%0d", p), 32'(bus.dig_en),
        ((p % DIV) < BLK || !lit[s]) ? 32'd0 : 32'd1 << s);
    chk($sformatf("dec_digit@%0d", p), 32'(bus.dec_digit), 32'((shown >> (4 * s)) & 16'hf));
    chk($sformatf("dec_dp@%0d", p), 32'(bus.dec_dp), 32'(dp[s]));
    chk($sformatf("frame_start@%0d", p), 32'(bus.frame_start), 32'(p == 0));
    chk($sformatf("load_ack@%0d", p), 32'(bus.load_ack), 32'(ack && p == 0));
  endtask
  initial begin
    logic [3:0] lit_a, lit_b;
`ifdef SEG_SCAN_LZB_EN
    lit_a = 4'b0011;
    lit_b = 4'b0001;
`else
    lit_a = 4'b1111;
    lit_b = 4'b1111;
`endif
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.digits_in = '0;
    bus.dp_in = '0;
    repeat (2) tick;
    rst = 1'b0;
    repeat (6) tick;
    chk("idle_dig_en", 32'(bus.dig_en), 0);
    chk("idle_dec_digit", 32'(bus.dec_digit), 0);
    chk("idle_dec_dp", 32'(bus.dec_dp), 0);
    chk("idle_frame_start", 32'(bus.frame_start), 0);
    chk("idle_load_ack", 32'(bus.load_ack), 0);
    bus.en = 1'b1;
    bus.load = 1'b1;
    bus.digits_in = 16'h4321;
    bus.dp_in = 4'b0101;
    for (int c = 0; c < 115; c++) begin
      tick;
      chk_scan(c % FRM, (c < 64) ? 16'h4321 : 16'h8765, 4'b0101, c == 0 || c == 64, 4'hf);
      if (c == 0) bus.load = 1'b0;
      if (c == 42) begin
        bus.load = 1'b1;
        bus.digits_in = 16'h8765;
      end
      if (c == 64) bus.load = 1'b0;
    end
    bus.en = 1'b0;
    tick;
    chk("en_off_dig_en", 32'(bus.dig_en), 0);
    chk("en_off_frame_start", 32'(bus.frame_start), 0);
    chk("en_off_load_ack", 32'(bus.load_ack), 0);
    repeat (3) tick;
    chk("idle2_dig_en", 32'(bus.dig_en), 0);
    bus.en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk_scan(c, 16'h8765, 4'b0101, 1'b0, 4'hf);
    end
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_dig_en", 32'(bus.dig_en), 0);
    chk("async_rst_dec_digit", 32'(bus.dec_digit), 0);
    chk("async_rst_dec_dp", 32'(bus.dec_dp), 0);
    bus.en = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_dig_en", 32'(bus.dig_en), 0);
    chk("post_rst_frame_start", 32'(bus.frame_start), 0);
    bus.en = 1'b1;
    bus.load = 1'b1;
    bus.digits_in = 16'h0050;
    bus.dp_in = 4'b0000;
    for (int c = 0; c < 96; c++) begin
      tick;
      chk_scan(c % FRM, (c < 32) ? 16'h0050 : 16'h0000, 4'b0000, c == 0 || c == 32,
               (c < 32) ? lit_a : lit_b);
      if (c == 5) bus.digits_in = 16'h0000;
      if (c == 32) bus.load = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
